results_encoder_module: RTL and testbench

- Reverse path of the 4-bit-to-7-bit results decoder.
- Accepts 7-bit result words over a valid/ready handshake and encodes each back to a 4-bit value.
- Buffers encoded words in a small FIFO, flags out-of-range words and counts them.
- Sits between the ALU result bus and the 4-bit register/LED consumer stage.

---
 rtl/results_encoder_module.sv | 93 +++++++++
 tb/tb_results_encoder_module.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/results_encoder_module.sv
// Encodes 7-bit result words to 4 bits and buffers them in a DEPTH-entry FIFO.
// Define RESULTS_ENC_WRAP_EN to truncate out-of-range words instead of saturating them.
module results_encoder_module #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               results,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               temp_results,
    output logic                     out_ovf,
    output logic [CNT_W-1:0]         ovf_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Each entry is {ovf, value}
    logic [4:0]       mem_q [DEPTH];
    logic [4:0]       mem_d [DEPTH];
    logic [4:0]       head;
    logic             push, pop;
    logic             enc_ovf;
    logic [3:0]       enc_val;

    always_comb begin
        enc_ovf = (results[6:4] != 3'b000);
`ifdef RESULTS_ENC_WRAP_EN
        enc_val = results[3:0];
`else
        enc_val = enc_ovf ? 4'hF : results[3:0];
`endif
    end

    assign in_ready   = (level_q != LW'(DEPTH));
    assign out_valid  = (level_q != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign head       = mem_q[rd_ptr_q];
    // Gate the head so an empty FIFO shows the reset values rather than stale data
    assign temp_results = out_valid ? head[3:0] : 4'h0;
    assign out_ovf      = out_valid ? head[4] : 1'b0;
    assign ovf_count    = cnt_q;
    assign fifo_level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {enc_ovf, enc_val};
            wr_ptr_d        = wr_ptr_q + AW'(1);
            if (enc_ovf && (cnt_q != '1))
                cnt_d = cnt_q + CNT_W'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_results_encoder_module.sv
// Self-checking bench for results_encoder_module using a queue-based reference model.
module tb_results_encoder_module;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [6:0]       results = '0;
    logic             in_ready, out_valid, out_ovf;
    logic [3:0]       temp_results;
    logic [CNT_W-1:0] ovf_count;
    logic [LW-1:0]    fifo_level;

    int checks = 0;
    int passes = 0;
    logic [4:0] mq[$];
    int mcount = 0;

    results_encoder_module #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .results(results), .out_valid(out_valid), .out_ready(out_ready),
        .temp_results(temp_results), .out_ovf(out_ovf), .ovf_count(ovf_count),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Reference encoding: values below 16 pass through, anything else is out of range.
    function automatic logic [4:0] enc_ref(input int r);
        if (r < 16) return {1'b0, 4'(r)};
`ifdef RESULTS_ENC_WRAP_EN
        return {1'b1, 4'(r % 16)};
`else
        return {1'b1, 4'd15};
`endif
    endfunction

    // Drive one cycle, advance the model across the edge, settle 1 time unit after it.
    task automatic cycle(input logic iv, input logic [6:0] r, input logic ordy, output bit acc);
        bit do_pop;
        in_valid  = iv;
        results   = r;
        out_ready = ordy;
        acc    = iv && (mq.size() < DEPTH);
        do_pop = ordy && (mq.size() > 0);
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            mcount = 0;
            acc = 1'b0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(enc_ref(int'(r)));
                if (enc_ref(int'(r)) >> 4 && mcount < CMAX) mcount++;
            end
        end
        #1;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 3 * DEPTH && mq.size() > 0; i++) cycle(1'b0, 7'h00, 1'b1, acc);
    endtask

    task automatic test_reset();
        bit acc;
        rst_n = 1'b0;
        cycle(1'b1, 7'h33, 1'b0, acc);
        cycle(1'b1, 7'h44, 1'b0, acc);
        rst_n = 1'b1;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else passes++;
        checks++; if (fifo_level !== '0) $display("FAIL reset_level got=%0d exp=0", fifo_level); else passes++;
        checks++; if (ovf_count !== '0) $display("FAIL reset_count got=%0d exp=0", ovf_count); else passes++;
        checks++; if (temp_results !== 4'h0) $display("FAIL reset_temp got=%h exp=0", temp_results); else passes++;
        checks++; if (out_ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", out_ovf); else passes++;
    endtask

    task automatic test_single();
        bit acc;
        cycle(1'b1, 7'h05, 1'b1, acc);
        checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", out_valid); else passes++;
        checks++; if (temp_results !== 4'h5) $display("FAIL single_temp got=%h exp=5", temp_results); else passes++;
        checks++; if (out_ovf !== 1'b0) $display("FAIL single_ovf got=%b exp=0", out_ovf); else passes++;
        checks++; if (fifo_level !== LW'(1)) $display("FAIL single_level got=%0d exp=1", fifo_level); else passes++;
        cycle(1'b0, 7'h00, 1'b1, acc);
        checks++; if (fifo_level !== '0 || out_valid !== 1'b0)
            $display("FAIL single_pop level=%0d valid=%b exp 0/0", fifo_level, out_valid); else passes++;
    endtask

    task automatic test_ovf();
        bit acc;
        logic [3:0] exp_a, exp_b;
`ifdef RESULTS_ENC_WRAP_EN
        exp_a = 4'hA; exp_b = 4'hF;
`else
        exp_a = 4'hF; exp_b = 4'hF;
`endif
        cycle(1'b1, 7'h1A, 1'b0, acc);
        cycle(1'b1, 7'h7F, 1'b0, acc);
        checks++; if (ovf_count !== CNT_W'(2)) $display("FAIL ovf_count got=%0d exp=2", ovf_count); else passes++;
        checks++; if (temp_results !== exp_a || out_ovf !== 1'b1)
            $display("FAIL ovf_first got=%h/%b exp=%h/1", temp_results, out_ovf, exp_a); else passes++;
        cycle(1'b0, 7'h00, 1'b1, acc);
        checks++; if (temp_results !== exp_b || out_ovf !== 1'b1)
            $display("FAIL ovf_second got=%h/%b exp=%h/1", temp_results, out_ovf, exp_b); else passes++;
        drain();
    endtask

    task automatic test_fill_drain();
        bit acc;
        int nxt = 0;
        int got = 0;
        for (int c = 0; c < 6; c++) begin
            cycle(1'b1, 7'(nxt), 1'b0, acc);
            if (acc) nxt++;
        end
        checks++; if (fifo_level !== LW'(DEPTH)) $display("FAIL full_level got=%0d exp=%0d", fifo_level, DEPTH); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got=%b exp=0", in_ready); else passes++;
        checks++; if (temp_results !== 4'h0) $display("FAIL full_head got=%h exp=0", temp_results); else passes++;
        got = 1;
        // Pop while full: the held word must not enter this cycle
        cycle(1'b1, 7'(nxt), 1'b1, acc);
        if (acc) nxt++;
        checks++; if (fifo_level !== LW'(DEPTH - 1)) $display("FAIL full_pop_level got=%0d exp=%0d", fifo_level, DEPTH - 1); else passes++;
        for (int c = 0; c < 20 && got < 5; c++) begin
            if (out_valid) begin
                checks++; if (temp_results !== 4'(got)) $display("FAIL drain_order got=%h exp=%h", temp_results, 4'(got)); else passes++;
                got++;
            end
            cycle(nxt <= 4, 7'(nxt), 1'b1, acc);
            if (acc) nxt++;
        end
        checks++; if (got != 5) $display("FAIL drain_count got=%0d exp=5", got); else passes++;
        checks++; if (fifo_level !== '0) $display("FAIL drain_empty got=%0d exp=0", fifo_level); else passes++;
    endtask

    task automatic test_back_to_back();
        bit acc;
        cycle(1'b1, 7'($urandom_range(0, 127)), 1'b0, acc);
        cycle(1'b1, 7'($urandom_range(0, 127)), 1'b0, acc);
        for (int c = 0; c < 20; c++) begin
            checks++; if (fifo_level !== LW'(2)) $display("FAIL b2b_level c=%0d got=%0d exp=2", c, fifo_level); else passes++;
            checks++; if ({out_ovf, temp_results} !== mq[0])
                $display("FAIL b2b_head c=%0d got=%h exp=%h", c, {out_ovf, temp_results}, mq[0]); else passes++;
            cycle(1'b1, 7'($urandom_range(0, 127)), 1'b1, acc);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bit acc;
        for (int c = 0; c < 3; c++) cycle(1'b1, 7'(c + 1), 1'b0, acc);
        checks++; if (fifo_level !== LW'(3)) $display("FAIL mid_fill got=%0d exp=3", fifo_level); else passes++;
        rst_n = 1'b0;
        cycle(1'b1, 7'h7F, 1'b1, acc);
        rst_n = 1'b1;
        checks++; if (fifo_level !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL mid_reset level=%0d valid=%b ready=%b exp 0/0/1", fifo_level, out_valid, in_ready); else passes++;
        checks++; if (ovf_count !== '0 || temp_results !== 4'h0 || out_ovf !== 1'b0)
            $display("FAIL mid_reset_out cnt=%0d temp=%h ovf=%b exp 0/0/0", ovf_count, temp_results, out_ovf); else passes++;
        cycle(1'b1, 7'h09, 1'b0, acc);
        checks++; if (temp_results !== 4'h9 || out_valid !== 1'b1)
            $display("FAIL mid_after temp=%h valid=%b exp 9/1", temp_results, out_valid); else passes++;
        drain();
    endtask

    task automatic test_random();
        bit acc;
        logic [6:0] r;
        for (int c = 0; c < 400; c++) begin
            checks++; if (fifo_level !== LW'(mq.size()) || out_valid !== (mq.size() != 0) || in_ready !== (mq.size() != DEPTH))
                $display("FAIL rnd_flags c=%0d level=%0d valid=%b ready=%b exp_level=%0d", c, fifo_level, out_valid, in_ready, mq.size());
            else passes++;
            if (mq.size() > 0) begin
                checks++; if ({out_ovf, temp_results} !== mq[0])
                    $display("FAIL rnd_head c=%0d got=%h exp=%h", c, {out_ovf, temp_results}, mq[0]); else passes++;
            end
            checks++; if (ovf_count !== CNT_W'(mcount)) $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, ovf_count, mcount); else passes++;
            r = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
            cycle($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0, acc);
        end
        drain();
    endtask

    task automatic test_saturation();
        bit acc;
        for (int c = 0; c < CMAX + 40; c++) cycle(1'b1, 7'($urandom_range(16, 127)), 1'b1, acc);
        checks++; if (ovf_count !== CNT_W'(CMAX)) $display("FAIL sat_count got=%0d exp=%0d", ovf_count, CMAX); else passes++;
        checks++; if (mcount != CMAX) $display("FAIL sat_model got=%0d exp=%0d", mcount, CMAX); else passes++;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_ovf();
        test_fill_drain();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
